// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer sharing the single main-memory port between I-cache refills and D-cache refills/writes.
// Optional build macro MEM_ARB_ICACHE_PRIO_EN: fixed I-cache priority instead of round-robin.
module mem_port_arbiter #(
   parameter int LINE_WORDS = 4,
   parameter int LATENCY    = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          ic_req,
   input  logic [31:0]                   ic_addr,
   output logic                          ic_rvalid,
   output logic [31:0]                   ic_rdata,
   output logic [$clog2(LINE_WORDS)-1:0] ic_beat,
   output logic                          ic_done,
   input  logic                          dc_req,
   input  logic                          dc_we,
   input  logic [31:0]                   dc_addr,
   input  logic [31:0]                   dc_wdata,
   output logic                          dc_rvalid,
   output logic [31:0]                   dc_rdata,
   output logic [$clog2(LINE_WORDS)-1:0] dc_beat,
   output logic                          dc_done,
   output logic [31:0]                   mem_addr,
   output logic                          mem_we,
   output logic [31:0]                   mem_wdata,
   input  logic [31:0]                   mem_rdata,
   output logic                          busy
);

   localparam int BW = $clog2(LINE_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [31:0]   LINE_MASK = ~((32'd1 << (BW + 2)) - 32'd1);
   localparam logic [31:0]   WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [BW-1:0] beat_r, beat_s;
   logic          owner_dc_r, owner_dc_s;
   logic          we_r, we_s;
   logic [31:0]   addr_r, addr_s;
   logic [31:0]   wdata_r, wdata_s;
   logic          grant_dc_s;
   logic [31:0]   sel_addr_s;
   logic          xfer_rd_s;

`ifdef MEM_ARB_ICACHE_PRIO_EN
   // Fixed priority: D-cache only wins when the I-cache is not asking.
   always_comb begin
      grant_dc_s = ~ic_req;
   end
`else
   logic last_dc_r, last_dc_s;

   // Round-robin: on a tie the requester not granted last wins.
   always_comb begin
      if (ic_req && dc_req) begin
         grant_dc_s = ~last_dc_r;
      end else begin
         grant_dc_s = dc_req;
      end
   end

   // Last-grant memory starts at D-cache so the I-cache takes the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_dc_r <= 1'b1;
      end else begin
         last_dc_r <= last_dc_s;
      end
   end

   // Remember the winner only when a grant is actually issued.
   always_comb begin
      if ((state_r == ST_IDLE) && (ic_req || dc_req)) begin
         last_dc_s = grant_dc_s;
      end else begin
         last_dc_s = last_dc_r;
      end
   end
`endif

   assign sel_addr_s = grant_dc_s ? dc_addr : ic_addr;

   // Next-state and transaction-context sequencing.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      beat_s     = beat_r;
      owner_dc_s = owner_dc_r;
      we_s       = we_r;
      addr_s     = addr_r;
      wdata_s    = wdata_r;
      case (state_r)
         ST_IDLE: begin
            if (ic_req || dc_req) begin
               owner_dc_s = grant_dc_s;
               we_s       = grant_dc_s & dc_we;
               addr_s     = (grant_dc_s && dc_we) ? (sel_addr_s & WORD_MASK)
                                                  : (sel_addr_s & LINE_MASK);
               wdata_s    = dc_wdata;
               cnt_s      = WAIT_LOAD;
               beat_s     = {BW{1'b0}};
               state_s    = ST_WAIT;
            end else begin
               state_s    = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_r == {CW{1'b0}}) begin
               beat_s  = {BW{1'b0}};
               state_s = ST_XFER;
            end else begin
               cnt_s   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
            end
         end
         ST_XFER: begin
            if (we_r || (beat_r == LAST_BEAT)) begin
               state_s = ST_DONE;
            end else begin
               beat_s  = beat_r + {{(BW-1){1'b0}}, 1'b1};
            end
         end
         ST_DONE: begin
            beat_s  = {BW{1'b0}};
            cnt_s   = {CW{1'b0}};
            state_s = ST_IDLE;
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and context registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         cnt_r      <= {CW{1'b0}};
         beat_r     <= {BW{1'b0}};
         owner_dc_r <= 1'b0;
         we_r       <= 1'b0;
         addr_r     <= 32'd0;
         wdata_r    <= 32'd0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         beat_r     <= beat_s;
         owner_dc_r <= owner_dc_s;
         we_r       <= we_s;
         addr_r     <= addr_s;
         wdata_r    <= wdata_s;
      end
   end

   // Outputs decode registered state; only read data passes straight through.
   assign xfer_rd_s = (state_r == ST_XFER) && !we_r;
   assign ic_rvalid = xfer_rd_s && !owner_dc_r;
   assign dc_rvalid = xfer_rd_s && owner_dc_r;
   assign ic_rdata  = ic_rvalid ? mem_rdata : 32'd0;
   assign dc_rdata  = dc_rvalid ? mem_rdata : 32'd0;
   assign ic_beat   = ic_rvalid ? beat_r : {BW{1'b0}};
   assign dc_beat   = dc_rvalid ? beat_r : {BW{1'b0}};
   assign ic_done   = (state_r == ST_DONE) && !owner_dc_r;
   assign dc_done   = (state_r == ST_DONE) && owner_dc_r;
   assign mem_we    = (state_r == ST_XFER) && we_r;
   assign mem_wdata = mem_we ? wdata_r : 32'd0;
   assign mem_addr  = mem_we    ? addr_r :
                      xfer_rd_s ? (addr_r + 32'({beat_r, 2'b00})) : 32'd0;
   assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (default and LATENCY=1/LINE_WORDS=8 instances).
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ic_req, dc_req, dc_we;
   logic [31:0] ic_addr, dc_addr, dc_wdata;
   logic        ic_rvalid, ic_done, dc_rvalid, dc_done, mem_we, busy;
   logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  ic_beat, dc_beat;

   logic        d2_ic_req, d2_dc_req, d2_dc_we;
   logic [31:0] d2_ic_addr, d2_dc_addr, d2_dc_wdata;
   logic        d2_ic_rvalid, d2_ic_done, d2_dc_rvalid, d2_dc_done, d2_mem_we, d2_busy;
   logic [31:0] d2_ic_rdata, d2_dc_rdata, d2_mem_addr, d2_mem_wdata, d2_mem_rdata;
   logic [2:0]  d2_ic_beat, d2_dc_beat;

   logic [31:0] mem1 [0:2047];
   logic [31:0] mem2 [0:2047];
   bit          mem_init = 1'b0;
   logic [31:0] img [0:3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_rvalid(ic_rvalid), .ic_rdata(ic_rdata),
      .ic_beat(ic_beat), .ic_done(ic_done),
      .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata), .dc_beat(dc_beat), .dc_done(dc_done),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   mem_port_arbiter #(.LINE_WORDS(8), .LATENCY(1)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .ic_req(d2_ic_req), .ic_addr(d2_ic_addr), .ic_rvalid(d2_ic_rvalid), .ic_rdata(d2_ic_rdata),
      .ic_beat(d2_ic_beat), .ic_done(d2_ic_done),
      .dc_req(d2_dc_req), .dc_we(d2_dc_we), .dc_addr(d2_dc_addr), .dc_wdata(d2_dc_wdata),
      .dc_rvalid(d2_dc_rvalid), .dc_rdata(d2_dc_rdata), .dc_beat(d2_dc_beat), .dc_done(d2_dc_done),
      .mem_addr(d2_mem_addr), .mem_we(d2_mem_we), .mem_wdata(d2_mem_wdata), .mem_rdata(d2_mem_rdata),
      .busy(d2_busy)
   );

   assign mem_rdata    = mem1[mem_addr[12:2]];
   assign d2_mem_rdata = mem2[d2_mem_addr[12:2]];

   // Memory model for the default instance: image load on first edge, then writes.
   always @(posedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 2048; i++) mem1[i] <= 32'd0;
         mem1[11'h400] <= 32'h00A0_0093;
         mem1[11'h401] <= 32'h0640_2223;
         mem1[11'h402] <= 32'h0640_2103;
         mem1[11'h403] <= 32'h0680_2183;
         mem_init <= 1'b1;
      end else if (mem_we) begin
         mem1[mem_addr[12:2]] <= mem_wdata;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   int ic_first, ic_second, dc_fin, beats, done_c, bad;

   initial begin
      img[0] = 32'h00A0_0093; img[1] = 32'h0640_2223;
      img[2] = 32'h0640_2103; img[3] = 32'h0680_2183;
      for (int i = 0; i < 2048; i++) mem2[i] = 32'hA000_0000 + i;
      rst_n = 1'b0;
      ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
      ic_addr = 32'd0; dc_addr = 32'd0; dc_wdata = 32'd0;
      d2_ic_req = 1'b0; d2_dc_req = 1'b0; d2_dc_we = 1'b0;
      d2_ic_addr = 32'd0; d2_dc_addr = 32'd0; d2_dc_wdata = 32'd0;
      #2;
      check("rst_busy", busy, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_outs", {ic_rvalid, ic_done, dc_rvalid, dc_done, mem_we}, 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();

      // I-cache line refill at 0x1008 -> base 0x1000
      ic_addr = 32'h0000_1008; ic_req = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         check("t1_rvalid", ic_rvalid, (c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) begin
            check("t1_beat", ic_beat, c - 3);
            check("t1_data", ic_rdata, img[c-3]);
            check("t1_addr", mem_addr, 32'h1000 + 4 * (c - 3));
         end
         check("t1_done", ic_done, c == 7);
         check("t1_busy", busy, c <= 7);
         check("t1_dc_quiet", {dc_rvalid, dc_done}, 32'd0);
         if (c == 7) ic_req = 1'b0;
      end

      // D-cache word write, then refill of the same line
      dc_we = 1'b1; dc_addr = 32'h64; dc_wdata = 32'd10; dc_req = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         cyc();
         check("t2_we", mem_we, c == 3);
         if (c == 3) begin
            check("t2_addr", mem_addr, 32'h64);
            check("t2_wdata", mem_wdata, 32'd10);
         end
         check("t2_done", dc_done, c == 4);
         check("t2_rvalid", dc_rvalid, 32'd0);
         if (c == 4) dc_req = 1'b0;
      end
      cyc();
      check("t2_gap_busy", busy, 32'd0);
      dc_we = 1'b0; dc_addr = 32'h60; dc_req = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         cyc();
         check("t2r_rvalid", dc_rvalid, (c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) check("t2r_data", dc_rdata, (c == 4) ? 32'd10 : 32'd0);
         check("t2r_done", dc_done, c == 7);
         if (c == 7) dc_req = 1'b0;
      end
      cyc();

      // Simultaneous requests, then I-cache re-raises for a second tie
      ic_addr = 32'h1000; dc_addr = 32'h60; ic_req = 1'b1; dc_req = 1'b1;
      ic_first = 0; ic_second = 0; dc_fin = 0;
      for (int c = 1; c <= 24; c++) begin
         cyc();
         if (ic_done) begin
            if (ic_first == 0) ic_first = c; else ic_second = c;
            ic_req = 1'b0;
         end
         if (dc_done) begin
            dc_fin = c;
            dc_req = 1'b0;
         end
         if (c == 8 || c == 16) check("t3_gap_busy", busy, 32'd0);
         if (c == 8) ic_req = 1'b1;
`ifdef MEM_ARB_ICACHE_PRIO_EN
         if (c == 11) check("t3_second_owner", {ic_rvalid, dc_rvalid}, 32'd2);
`else
         if (c == 11) check("t3_second_owner", {ic_rvalid, dc_rvalid}, 32'd1);
`endif
      end
      check("t3_ic_first", ic_first, 32'd7);
`ifdef MEM_ARB_ICACHE_PRIO_EN
      check("t3_ic_second", ic_second, 32'd15);
      check("t3_dc_done", dc_fin, 32'd23);
`else
      check("t3_dc_done", dc_fin, 32'd15);
      check("t3_ic_second", ic_second, 32'd23);
`endif

      // Reset during beat 2 of an I-cache refill
      ic_addr = 32'h1000; ic_req = 1'b1;
      for (int c = 1; c <= 5; c++) cyc();
      check("t4_pre_beat", ic_beat, 32'd2);
      check("t4_pre_rvalid", ic_rvalid, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t4_rvalid", ic_rvalid, 32'd0);
      check("t4_rdata", ic_rdata, 32'd0);
      check("t4_mem_addr", mem_addr, 32'd0);
      check("t4_busy", busy, 32'd0);
      ic_req = 1'b0;
      cyc();
      rst_n = 1'b1;
      bad = 0;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         if (ic_done || busy || ic_rvalid) bad++;
      end
      check("t4_after_release", bad, 32'd0);

      // Request withdrawn during WAIT still completes
      ic_req = 1'b1; beats = 0; done_c = 0;
      for (int c = 1; c <= 9; c++) begin
         cyc();
         if (c == 1) ic_req = 1'b0;
         if (ic_rvalid) beats++;
         if (ic_done) done_c = c;
      end
      check("t5_beats", beats, 32'd4);
      check("t5_done", done_c, 32'd7);

      // LATENCY=1, LINE_WORDS=8: D-cache refill at 0x1FFC -> base 0x1FE0
      d2_dc_addr = 32'h1FFC; d2_dc_req = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         cyc();
         check("t6_rvalid", d2_dc_rvalid, (c >= 2 && c <= 9));
         if (c >= 2 && c <= 9) begin
            check("t6_beat", d2_dc_beat, c - 2);
            check("t6_addr", d2_mem_addr, 32'h1FE0 + 4 * (c - 2));
            check("t6_data", d2_dc_rdata, 32'hA000_07F8 + (c - 2));
         end
         check("t6_done", d2_dc_done, c == 10);
         check("t6_ic_quiet", {d2_ic_rvalid, d2_ic_done, d2_mem_we, d2_ic_beat}, 32'd0);
         if (c == 10) d2_dc_req = 1'b0;
      end
      check("t6_idle", {d2_busy, d2_ic_rdata == 32'd0, d2_mem_wdata == 32'd0}, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
